scene_compositor: RTL and testbench

Per-pixel scene compositor for the game display. It snapshots the game-state outputs of the game controller once per frame, at the frame-start pulse, so that no frame shows a mix of old and new state. For each pixel coordinate requested by the VGA timing generator, it returns a 24-bit colour after a fixed 2-cycle pipeline. It also generates the per-frame hit-flash effect whenever a character's HP drops.

---
 rtl/scene_compositor.sv | 181 ++++++++++++++++++
 tb/tb_scene_compositor.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scene_compositor.sv
// scene_compositor: per-pixel colour for the game display.
// Game state is snapshotted once per frame. Each pixel request returns a
// 24-bit colour two cycles later, one pixel per cycle. A character blinks
// for a number of frames after its HP drops.
module scene_compositor #(
  parameter int SPR_W        = 32,
  parameter int SPR_H        = 48,
  parameter int BUL_S        = 8,
  parameter int FLASH_FRAMES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_frame_start,
  input  logic               i_valid,
  input  logic [10:0]        i_px,
  input  logic [9:0]         i_py,
  input  logic [1:0]         i_state,
  input  logic signed [10:0] i_player_x,
  input  logic signed [9:0]  i_player_y,
  input  logic [1:0]         i_player_hp,
  input  logic               i_player_shield,
  input  logic               i_player_squat,
  input  logic signed [10:0] i_enemy_x,
  input  logic signed [9:0]  i_enemy_y,
  input  logic [1:0]         i_enemy_hp,
  input  logic               i_enemy_shield,
  input  logic               i_enemy_squat,
  input  logic signed [10:0] i_goodbullet_x,
  input  logic signed [9:0]  i_goodbullet_y,
  input  logic               i_goodbullet_isE,
  input  logic signed [10:0] i_badbullet_x,
  input  logic signed [9:0]  i_badbullet_y,
  input  logic               i_badbullet_isE,
  output logic               o_valid,
  output logic [23:0]        o_rgb
);

  localparam logic signed [11:0] SW  = 12'(SPR_W);
  localparam logic signed [11:0] SH  = 12'(SPR_H);
  localparam logic signed [11:0] SH2 = 12'(SPR_H / 2);
  localparam logic signed [11:0] BS  = 12'(BUL_S);

  logic [1:0]         st;
  logic signed [10:0] pl_x, en_x, gb_x, bb_x;
  logic signed [9:0]  pl_y, en_y, gb_y, bb_y;
  logic [1:0]         pl_hp, en_hp;
  logic               pl_sh, pl_sq, en_sh, en_sq, gb_e, bb_e;
  logic [4:0]         pl_fl, en_fl;

  // Shadow copy of the game state, refreshed only at frame start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= 2'b00;
      pl_x <= '0; pl_y <= '0; pl_hp <= 2'd3; pl_sh <= 1'b0; pl_sq <= 1'b0;
      en_x <= '0; en_y <= '0; en_hp <= 2'd3; en_sh <= 1'b0; en_sq <= 1'b0;
      gb_x <= '0; gb_y <= '0; gb_e <= 1'b0;
      bb_x <= '0; bb_y <= '0; bb_e <= 1'b0;
    end else if (i_frame_start) begin
      st <= i_state;
      pl_x <= i_player_x; pl_y <= i_player_y; pl_hp <= i_player_hp;
      pl_sh <= i_player_shield; pl_sq <= i_player_squat;
      en_x <= i_enemy_x; en_y <= i_enemy_y; en_hp <= i_enemy_hp;
      en_sh <= i_enemy_shield; en_sq <= i_enemy_squat;
      gb_x <= i_goodbullet_x; gb_y <= i_goodbullet_y; gb_e <= i_goodbullet_isE;
      bb_x <= i_badbullet_x; bb_y <= i_badbullet_y; bb_e <= i_badbullet_isE;
    end
  end

  // Per-frame flash counters: reload on an HP drop during play, else count down
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pl_fl <= '0;
      en_fl <= '0;
    end else if (i_frame_start) begin
      if (i_state != 2'b01) begin
        pl_fl <= '0;
        en_fl <= '0;
      end else begin
        if (st == 2'b01 && i_player_hp < pl_hp) pl_fl <= 5'(FLASH_FRAMES);
        else if (pl_fl != 5'd0)                 pl_fl <= pl_fl - 5'd1;
        if (st == 2'b01 && i_enemy_hp < en_hp)  en_fl <= 5'(FLASH_FRAMES);
        else if (en_fl != 5'd0)                 en_fl <= en_fl - 5'd1;
      end
    end
  end

  function automatic logic in_rng(logic signed [11:0] p, logic signed [11:0] lo,
                                  logic signed [11:0] hi);
    return (p >= lo) && (p < hi);
  endfunction

  logic signed [11:0] sx, sy;
  logic signed [11:0] plx, ply, enx, eny, gbx, gby, bbx, bby, pl_top, en_top;
  logic hit_pl, hit_en, hit_gb, hit_bb, hit_php, hit_ehp;

  assign sx  = $signed({1'b0, i_px});
  assign sy  = $signed({2'b00, i_py});
  assign plx = {pl_x[10], pl_x};
  assign enx = {en_x[10], en_x};
  assign gbx = {gb_x[10], gb_x};
  assign bbx = {bb_x[10], bb_x};
  assign ply = {{2{pl_y[9]}}, pl_y};
  assign eny = {{2{en_y[9]}}, en_y};
  assign gby = {{2{gb_y[9]}}, gb_y};
  assign bby = {{2{bb_y[9]}}, bb_y};
  // Squatting drops the top edge by half a sprite; the bottom edge stays put
  assign pl_top = ply + (pl_sq ? SH2 : 12'sd0);
  assign en_top = eny + (en_sq ? SH2 : 12'sd0);

  assign hit_pl = in_rng(sx, plx, plx + SW) && in_rng(sy, pl_top, ply + SH) &&
                  !(pl_fl != 5'd0 && pl_fl[1]);
  assign hit_en = in_rng(sx, enx, enx + SW) && in_rng(sy, en_top, eny + SH) &&
                  !(en_fl != 5'd0 && en_fl[1]);
  assign hit_gb = gb_e && in_rng(sx, gbx, gbx + BS) && in_rng(sy, gby, gby + BS);
  assign hit_bb = bb_e && in_rng(sx, bbx, bbx + BS) && in_rng(sy, bby, bby + BS);

  // HP bar segments: three 16x8 blocks, player from the left, enemy from the right
  always_comb begin
    hit_php = 1'b0;
    hit_ehp = 1'b0;
    if (i_py >= 10'd8 && i_py <= 10'd15) begin
      for (int k = 0; k < 3; k++) begin
        if (2'(k) < pl_hp && i_px >= 11'(8 + 20 * k) && i_px <= 11'(23 + 20 * k))
          hit_php = 1'b1;
        if (2'(k) < en_hp && i_px >= 11'(616 - 20 * k) && i_px <= 11'(631 - 20 * k))
          hit_ehp = 1'b1;
      end
    end
  end

  logic       s1_valid, s1_bb, s1_gb, s1_pl, s1_pl_sh, s1_en, s1_en_sh, s1_php, s1_ehp;
  logic [1:0] s1_st;

  // Stage 1: register the request with all hit flags from the current snapshot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0; s1_st <= 2'b00;
      s1_bb <= 1'b0; s1_gb <= 1'b0;
      s1_pl <= 1'b0; s1_pl_sh <= 1'b0; s1_en <= 1'b0; s1_en_sh <= 1'b0;
      s1_php <= 1'b0; s1_ehp <= 1'b0;
    end else begin
      s1_valid <= i_valid; s1_st <= st;
      s1_bb <= hit_bb; s1_gb <= hit_gb;
      s1_pl <= hit_pl; s1_pl_sh <= pl_sh; s1_en <= hit_en; s1_en_sh <= en_sh;
      s1_php <= hit_php; s1_ehp <= hit_ehp;
    end
  end

  logic [23:0] colour;

  // Colour priority: bullets over characters over HP bars over background
  always_comb begin
    colour = 24'h202040;
    case (s1_st)
      2'b00: colour = 24'h0000FF;
      2'b10: colour = 24'h00FF00;
      2'b11: colour = 24'hFF0000;
      default: begin
        if (s1_bb)       colour = 24'hFF0000;
        else if (s1_gb)  colour = 24'hFFFFFF;
        else if (s1_pl)  colour = s1_pl_sh ? 24'hFFFF00 : 24'h00C0FF;
        else if (s1_en)  colour = s1_en_sh ? 24'hFFFF00 : 24'hFF6000;
        else if (s1_php) colour = 24'h00FF00;
        else if (s1_ehp) colour = 24'hFF00FF;
        else             colour = 24'h202040;
      end
    endcase
  end

  // Stage 2: registered output, forced to zero when no pixel is valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_rgb   <= 24'h0;
    end else begin
      o_valid <= s1_valid;
      o_rgb   <= s1_valid ? colour : 24'h0;
    end
  end

endmodule

// File: tb/tb_scene_compositor.sv
// Testbench for scene_compositor: directed scenarios with literal colours
// plus randomized game state and pixel requests against a behavioural model.
`timescale 1ns/1ps
module tb_scene_compositor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               i_frame_start = 1'b0, i_valid = 1'b0;
  logic [10:0]        i_px = '0;
  logic [9:0]         i_py = '0;
  logic [1:0]         i_state = 2'b00;
  logic signed [10:0] i_player_x = '0, i_enemy_x = '0, i_goodbullet_x = '0, i_badbullet_x = '0;
  logic signed [9:0]  i_player_y = '0, i_enemy_y = '0, i_goodbullet_y = '0, i_badbullet_y = '0;
  logic [1:0]         i_player_hp = 2'd3, i_enemy_hp = 2'd3;
  logic               i_player_shield = 1'b0, i_player_squat = 1'b0;
  logic               i_enemy_shield = 1'b0, i_enemy_squat = 1'b0;
  logic               i_goodbullet_isE = 1'b0, i_badbullet_isE = 1'b0;
  logic               o_valid;
  logic [23:0]        o_rgb;

  scene_compositor dut (
    .clk(clk), .rst(rst), .i_frame_start(i_frame_start), .i_valid(i_valid),
    .i_px(i_px), .i_py(i_py), .i_state(i_state),
    .i_player_x(i_player_x), .i_player_y(i_player_y), .i_player_hp(i_player_hp),
    .i_player_shield(i_player_shield), .i_player_squat(i_player_squat),
    .i_enemy_x(i_enemy_x), .i_enemy_y(i_enemy_y), .i_enemy_hp(i_enemy_hp),
    .i_enemy_shield(i_enemy_shield), .i_enemy_squat(i_enemy_squat),
    .i_goodbullet_x(i_goodbullet_x), .i_goodbullet_y(i_goodbullet_y),
    .i_goodbullet_isE(i_goodbullet_isE),
    .i_badbullet_x(i_badbullet_x), .i_badbullet_y(i_badbullet_y),
    .i_badbullet_isE(i_badbullet_isE),
    .o_valid(o_valid), .o_rgb(o_rgb)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Behavioural model of the snapshot
  int m_st, m_php, m_ehp, m_pfl, m_efl;
  int m_px, m_py, m_ex, m_ey, m_gx, m_gy, m_bx, m_by;
  bit m_psh, m_psq, m_esh, m_esq, m_ge, m_be;

  // Expected-output pipeline (two cycles deep)
  bit          p1_v, p2_v, p1_l, p2_l;
  logic [23:0] p1_rgb, p2_rgb, p1_lit, p2_lit;

  function automatic bit inbox(int px, int py, int x, int y, int w, int h);
    return px >= x && px < x + w && py >= y && py < y + h;
  endfunction

  function automatic bit flashing(int cnt);
    return cnt != 0 && ((cnt / 2) % 2 == 1);
  endfunction

  function automatic logic [23:0] model_rgb(int px, int py);
    if (m_st == 0) return 24'h0000FF;
    if (m_st == 2) return 24'h00FF00;
    if (m_st == 3) return 24'hFF0000;
    if (m_be && inbox(px, py, m_bx, m_by, 8, 8)) return 24'hFF0000;
    if (m_ge && inbox(px, py, m_gx, m_gy, 8, 8)) return 24'hFFFFFF;
    if (!flashing(m_pfl) && inbox(px, py, m_px, m_py + (m_psq ? 24 : 0), 32, m_psq ? 24 : 48))
      return m_psh ? 24'hFFFF00 : 24'h00C0FF;
    if (!flashing(m_efl) && inbox(px, py, m_ex, m_ey + (m_esq ? 24 : 0), 32, m_esq ? 24 : 48))
      return m_esh ? 24'hFFFF00 : 24'hFF6000;
    for (int k = 0; k < m_php; k++)
      if (py >= 8 && py <= 15 && px >= 8 + 20 * k && px <= 23 + 20 * k) return 24'h00FF00;
    for (int k = 0; k < m_ehp; k++)
      if (py >= 8 && py <= 15 && px >= 616 - 20 * k && px <= 631 - 20 * k) return 24'hFF00FF;
    return 24'h202040;
  endfunction

  task automatic model_reset();
    m_st = 0; m_php = 3; m_ehp = 3; m_pfl = 0; m_efl = 0;
    m_px = 0; m_py = 0; m_ex = 0; m_ey = 0; m_gx = 0; m_gy = 0; m_bx = 0; m_by = 0;
    m_psh = 0; m_psq = 0; m_esh = 0; m_esq = 0; m_ge = 0; m_be = 0;
    p1_v = 0; p2_v = 0; p1_l = 0; p2_l = 0;
    p1_rgb = '0; p2_rgb = '0; p1_lit = '0; p2_lit = '0;
  endtask

  task automatic model_snapshot();
    int ns, nph, neh;
    ns = int'(i_state); nph = int'(i_player_hp); neh = int'(i_enemy_hp);
    if (ns != 1) begin
      m_pfl = 0; m_efl = 0;
    end else begin
      if (m_st == 1 && nph < m_php) m_pfl = 16; else if (m_pfl > 0) m_pfl--;
      if (m_st == 1 && neh < m_ehp) m_efl = 16; else if (m_efl > 0) m_efl--;
    end
    m_st = ns; m_php = nph; m_ehp = neh;
    m_px = int'(i_player_x); m_py = int'(i_player_y);
    m_ex = int'(i_enemy_x);  m_ey = int'(i_enemy_y);
    m_gx = int'(i_goodbullet_x); m_gy = int'(i_goodbullet_y);
    m_bx = int'(i_badbullet_x);  m_by = int'(i_badbullet_y);
    m_psh = i_player_shield; m_psq = i_player_squat;
    m_esh = i_enemy_shield;  m_esq = i_enemy_squat;
    m_ge = i_goodbullet_isE; m_be = i_badbullet_isE;
  endtask

  // One clock: predict this cycle's request, clock it in, then advance the model
  task automatic cycle(input bit has_lit = 1'b0, input logic [23:0] lit = 24'h0);
    logic [23:0] e;
    e = i_valid ? model_rgb(int'(i_px), int'(i_py)) : 24'h0;
    @(posedge clk);
    p2_v = p1_v; p2_rgb = p1_rgb; p2_l = p1_l; p2_lit = p1_lit;
    p1_v = i_valid; p1_rgb = e; p1_l = has_lit; p1_lit = lit;
    if (i_frame_start) model_snapshot();
    #1;
  endtask

  task automatic req(input int x, input int y, input logic [23:0] lit);
    i_valid = 1'b1; i_px = 11'(x); i_py = 10'(y);
    cycle(1'b1, lit);
    i_valid = 1'b0;
  endtask

  task automatic frame();
    i_frame_start = 1'b1;
    cycle();
    i_frame_start = 1'b0;
  endtask

  task automatic flush();
    repeat (3) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Compare process: checks outputs on every falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (o_valid !== p2_v) begin
        errors++;
        $display("FAIL o_valid t=%0t got %b want %b", $time, o_valid, p2_v);
      end
      checks++;
      if (o_rgb !== (p2_v ? p2_rgb : 24'h0)) begin
        errors++;
        $display("FAIL rgb_model t=%0t got %06h want %06h", $time, o_rgb, p2_v ? p2_rgb : 24'h0);
      end
      if (p2_v && p2_l) begin
        checks++;
        if (o_rgb !== p2_lit) begin
          errors++;
          $display("FAIL rgb_literal t=%0t got %06h want %06h", $time, o_rgb, p2_lit);
        end
      end
    end
  end

  task automatic randomize_game();
    i_state = ($urandom_range(0, 9) < 7) ? 2'b01 : 2'($urandom_range(0, 3));
    if ($urandom_range(0, 2) == 0) i_player_hp = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 2) == 0) i_enemy_hp  = 2'($urandom_range(0, 3));
    i_player_x = 11'(int'($urandom_range(0, 720)) - 40);
    i_player_y = 10'(int'($urandom_range(0, 560)) - 60);
    i_enemy_x  = 11'(int'($urandom_range(0, 720)) - 40);
    i_enemy_y  = 10'(int'($urandom_range(0, 560)) - 60);
    i_goodbullet_x = 11'(int'($urandom_range(0, 660)) - 10);
    i_goodbullet_y = 10'(int'($urandom_range(0, 500)) - 10);
    i_badbullet_x  = 11'(int'($urandom_range(0, 660)) - 10);
    i_badbullet_y  = 10'(int'($urandom_range(0, 500)) - 10);
    {i_player_shield, i_player_squat, i_enemy_shield, i_enemy_squat} = 4'($urandom_range(0, 15));
    i_goodbullet_isE = 1'($urandom_range(0, 1));
    i_badbullet_isE  = 1'($urandom_range(0, 1));
  endtask

  function automatic int clampi(int v, int lo, int hi);
    return v < lo ? lo : (v > hi ? hi : v);
  endfunction

  task automatic random_pixel();
    int x, y;
    case ($urandom_range(0, 5))
      0: begin x = m_px + int'($urandom_range(0, 40)) - 4; y = m_py + int'($urandom_range(0, 56)) - 4; end
      1: begin x = m_ex + int'($urandom_range(0, 40)) - 4; y = m_ey + int'($urandom_range(0, 56)) - 4; end
      2: begin x = m_gx + int'($urandom_range(0, 12)) - 2; y = m_gy + int'($urandom_range(0, 12)) - 2; end
      3: begin x = m_bx + int'($urandom_range(0, 12)) - 2; y = m_by + int'($urandom_range(0, 12)) - 2; end
      4: begin x = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 70)) : int'($urandom_range(570, 639));
               y = int'($urandom_range(5, 18)); end
      default: begin x = int'($urandom_range(0, 639)); y = int'($urandom_range(0, 479)); end
    endcase
    i_px = 11'(clampi(x, 0, 639));
    i_py = 10'(clampi(y, 0, 479));
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();
    cmp_en = 1'b1;

    // Reset state: flat start colour before any frame start
    req(0, 0, 24'h0000FF);
    flush();

    // Play: player at (100,200), enemy at (300,100), bullets absent
    i_state = 2'b01;
    i_player_x = 11'sd100; i_player_y = 10'sd200;
    i_enemy_x  = 11'sd300; i_enemy_y  = 10'sd100;
    i_badbullet_x = 11'sd110; i_badbullet_y = 10'sd210;
    frame();
    req(100, 200, 24'h00C0FF);
    req(131, 247, 24'h00C0FF);
    req(132, 200, 24'h202040);
    req(8, 8, 24'h00FF00);
    req(591, 15, 24'hFF00FF);
    req(631, 8, 24'hFF00FF);
    flush();

    // Squat keeps the bottom edge
    i_player_squat = 1'b1;
    frame();
    req(100, 223, 24'h202040);
    req(100, 224, 24'h00C0FF);
    i_player_squat = 1'b0;

    // Bad bullet over the player
    i_badbullet_isE = 1'b1;
    frame();
    req(112, 212, 24'hFF0000);
    i_badbullet_isE = 1'b0;
    frame();
    req(112, 212, 24'h00C0FF);
    flush();

    // New x with frame start and request in the same cycle
    i_player_x = 11'sd400;
    i_frame_start = 1'b1; i_valid = 1'b1; i_px = 11'd100; i_py = 10'd200;
    cycle(1'b1, 24'h00C0FF);
    i_frame_start = 1'b0;
    req(100, 200, 24'h202040);
    flush();

    // Enemy hit flash: 3 -> 2
    i_enemy_hp = 2'd2;
    frame();
    req(310, 110, 24'hFF6000);
    for (int f = 1; f <= 16; f++) begin
      frame();
      req(310, 110, (f % 4 == 1 || f % 4 == 2) ? 24'h202040 : 24'hFF6000);
    end
    repeat (3) frame();
    req(310, 110, 24'hFF6000);

    // HP 0 draws no bar
    i_player_hp = 2'd0;
    frame();
    req(8, 8, 24'h202040);

    // Win / lose flat colours
    i_state = 2'b10; frame(); req(5, 5, 24'h00FF00);
    i_state = 2'b11; frame(); req(5, 5, 24'hFF0000);
    flush();

    // Randomized phase, with a reset in the middle
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) begin
        i_valid = 1'b1;
        random_pixel();
        cycle();
        do_reset();
        req(320, 240, 24'h0000FF);
      end
      if ($urandom_range(0, 7) == 0) randomize_game();
      i_frame_start = ($urandom_range(0, 29) == 0);
      i_valid = ($urandom_range(0, 9) < 8);
      random_pixel();
      cycle();
    end
    i_frame_start = 1'b0;
    i_valid = 1'b0;
    flush();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
